// File: rtl/ccc_lock_pkg.sv
// Shared types and helpers for the CCC lock sequencer.
package ccc_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILTER,
    RELEASE,
    RUN,
    LOST
  } state_t;

  // Widest divisor the clamp helper handles; channel divisors are zero-extended into it.
  localparam int MAX_DIV_W = 32;

  function automatic logic [MAX_DIV_W-1:0] clamp_div(input logic [MAX_DIV_W-1:0] d);
    return (d == '0) ? MAX_DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// One channel clock-enable divider: pulses ce once every div cycles while enabled.
module ce_divider
  import ccc_lock_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] term;

  // A divisor of 0 behaves as 1, so the terminal count is never negative.
  assign term = DIV_W'(clamp_div(MAX_DIV_W'(div)) - MAX_DIV_W'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (en) begin
      if (cnt == term) begin
        cnt <= '0;
        ce  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        ce  <= 1'b0;
      end
    end else begin
      ce <= 1'b0;
    end
  end

endmodule

// File: rtl/ccc_lock_sequencer.sv
// Filters PLL lock, releases channel resets one at a time with a stagger,
// drives per-channel clock enables and records loss-of-lock events.
module ccc_lock_sequencer
  import ccc_lock_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 8,
  parameter int LOCK_FILT = 64,
  parameter int STAGGER   = 16,
  parameter int CNT_W     = 8
) (
  input  logic                    SYSCLK,
  input  logic                    SYSRESET,
  input  logic                    PLL_LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic                    CLR_LOST,
  output logic [NUM_CH-1:0]       CH_RST,
  output logic [NUM_CH-1:0]       CE,
  output logic                    READY,
  output logic                    LOCK_LOST,
  output logic [CNT_W-1:0]        LOSS_COUNT
);

  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int STG_W  = $clog2(STAGGER + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                    state;
  logic                      lock_meta;
  logic                      lock_s;
  logic [FILT_W-1:0]         filt_cnt;
  logic [STG_W-1:0]          stg_cnt;
  logic [IDX_W-1:0]          idx;
  logic [NUM_CH*DIV_W-1:0]   div_q;
  logic                      lose;
  logic                      div_clr;

  assign lose    = ((state == RELEASE) || (state == RUN)) && !lock_s;
  assign div_clr = SYSRESET || lose || (state == IDLE) || (state == LOST);

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      state      <= IDLE;
      filt_cnt   <= '0;
      stg_cnt    <= '0;
      idx        <= '0;
      div_q      <= '0;
      CH_RST     <= '1;
      READY      <= 1'b0;
      LOCK_LOST  <= 1'b0;
      LOSS_COUNT <= '0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;

      if (CLR_LOST) LOCK_LOST <= 1'b0;

      case (state)
        IDLE: begin
          CH_RST   <= '1;
          READY    <= 1'b0;
          filt_cnt <= '0;
          if (lock_s) state <= FILTER;
        end

        FILTER: begin
          if (!lock_s) begin
            state    <= IDLE;
            filt_cnt <= '0;
          end else if (filt_cnt == FILT_W'(LOCK_FILT - 1)) begin
            state   <= RELEASE;
            div_q   <= DIV;
            stg_cnt <= '0;
            idx     <= '0;
          end else begin
            filt_cnt <= filt_cnt + 1'b1;
          end
        end

        RELEASE, RUN: begin
          if (lose) begin
            state  <= LOST;
            CH_RST <= '1;
            READY  <= 1'b0;
            // NOTE: this non-blocking set comes after the CLR_LOST clear above,
            // so a loss in the same cycle as a clear request leaves the flag set.
            LOCK_LOST <= 1'b1;
            if (LOSS_COUNT != '1) LOSS_COUNT <= LOSS_COUNT + 1'b1;
          end else if (state == RELEASE) begin
            if (stg_cnt == '0) begin
              CH_RST[idx] <= 1'b0;
              stg_cnt     <= STG_W'(STAGGER - 1);
              idx         <= idx + 1'b1;
              if (idx == IDX_W'(NUM_CH - 1)) begin
                state <= RUN;
                READY <= 1'b1;
              end
            end else begin
              stg_cnt <= stg_cnt - 1'b1;
            end
          end
        end

        LOST:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Each divider runs only once its own channel is out of reset.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ce_divider #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk(SYSCLK),
      .clr(div_clr),
      .en (!CH_RST[k]),
      .div(div_q[k*DIV_W +: DIV_W]),
      .ce (CE[k])
    );
  end

endmodule
